// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one external ALU between two requesters.
// Each accepted request drives the ALU for one cycle and is answered on its own response port.
module alu_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [2*DATA_WIDTH-1:0] req_op1,
    input  logic [2*DATA_WIDTH-1:0] req_op2,
    input  logic [2*CTRL_WIDTH-1:0] req_ctrl,
    output logic [1:0]              rsp_valid,
    input  logic [1:0]              rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_sum,
    output logic                    rsp_eq,
    output logic [DATA_WIDTH-1:0]   alu_op1,
    output logic [DATA_WIDTH-1:0]   alu_op2,
    output logic [CTRL_WIDTH-1:0]   alu_ctrl,
    input  logic [DATA_WIDTH-1:0]   alu_sum,
    input  logic                    alu_eq
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    state_t                r_state;
    logic                  r_ptr;
    logic                  r_grant;
    logic [1:0]            r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_sum;
    logic                  r_rsp_eq;
    logic [DATA_WIDTH-1:0] r_alu_op1;
    logic [DATA_WIDTH-1:0] r_alu_op2;
    logic [CTRL_WIDTH-1:0] r_alu_ctrl;

    logic                  w_grant_vld;
    logic                  w_grant_idx;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_sel_op1;
    logic [DATA_WIDTH-1:0] w_sel_op2;
    logic [CTRL_WIDTH-1:0] w_sel_ctrl;

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = 1'b0;
        case (req_valid)
            2'b01: begin
                w_grant_vld = 1'b1;
                w_grant_idx = 1'b0;
            end
            2'b10: begin
                w_grant_vld = 1'b1;
                w_grant_idx = 1'b1;
            end
            2'b11: begin
                w_grant_vld = 1'b1;
                w_grant_idx = r_ptr;
            end
            default: ;
        endcase
    end

    // Accept only in IDLE, and never while reset is held so nothing is handshaken into a reset.
    assign w_accept  = (r_state == S_IDLE) && w_grant_vld && !rst;
    assign req_ready = w_accept ? (w_grant_idx ? 2'b10 : 2'b01) : 2'b00;

    assign w_sel_op1  = w_grant_idx ? req_op1[2*DATA_WIDTH-1:DATA_WIDTH] : req_op1[DATA_WIDTH-1:0];
    assign w_sel_op2  = w_grant_idx ? req_op2[2*DATA_WIDTH-1:DATA_WIDTH] : req_op2[DATA_WIDTH-1:0];
    assign w_sel_ctrl = w_grant_idx ? req_ctrl[2*CTRL_WIDTH-1:CTRL_WIDTH] : req_ctrl[CTRL_WIDTH-1:0];

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= 1'b0;
            r_grant     <= 1'b0;
            r_rsp_valid <= 2'b00;
            r_rsp_sum   <= '0;
            r_rsp_eq    <= 1'b0;
            r_alu_op1   <= '0;
            r_alu_op2   <= '0;
            r_alu_ctrl  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_alu_op1  <= w_sel_op1;
                        r_alu_op2  <= w_sel_op2;
                        r_alu_ctrl <= w_sel_ctrl;
                        r_grant    <= w_grant_idx;
                        r_state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_rsp_sum            <= alu_sum;
                    r_rsp_eq             <= alu_eq;
                    r_rsp_valid[r_grant] <= 1'b1;
                    r_state              <= S_RESP;
                end
                S_RESP: begin
                    // The served requester drops to low priority for the next contested grant.
                    if (rsp_ready[r_grant]) begin
                        r_rsp_valid <= 2'b00;
                        r_ptr       <= ~r_grant;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_sum   = r_rsp_sum;
    assign rsp_eq    = r_rsp_eq;
    assign alu_op1   = r_alu_op1;
    assign alu_op2   = r_alu_op2;
    assign alu_ctrl  = r_alu_ctrl;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small external ALU model (ctrl 1 = subtract, else add).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_alu_arbiter;

    localparam int DW = 32;
    localparam int CW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [2*DW-1:0] req_op1;
    logic [2*DW-1:0] req_op2;
    logic [2*CW-1:0] req_ctrl;
    logic [1:0]      rsp_valid;
    logic [1:0]      rsp_ready;
    logic [DW-1:0]   rsp_sum;
    logic            rsp_eq;
    logic [DW-1:0]   alu_op1;
    logic [DW-1:0]   alu_op2;
    logic [CW-1:0]   alu_ctrl;
    logic [DW-1:0]   alu_sum;
    logic            alu_eq;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign alu_sum = (alu_ctrl == 3'd1) ? alu_op1 - alu_op2 : alu_op1 + alu_op2;
    assign alu_eq  = (alu_op1 == alu_op2);

    alu_arbiter #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op1   (req_op1),
        .req_op2   (req_op2),
        .req_ctrl  (req_ctrl),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_eq    (rsp_eq),
        .alu_op1   (alu_op1),
        .alu_op2   (alu_op2),
        .alu_ctrl  (alu_ctrl),
        .alu_sum   (alu_sum),
        .alu_eq    (alu_eq)
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [DW-1:0] op1, input logic [DW-1:0] op2,
                           input logic [CW-1:0] ctrl);
        req_op1[i*DW +: DW]  = op1;
        req_op2[i*DW +: DW]  = op2;
        req_ctrl[i*CW +: CW] = ctrl;
    endtask

    // Holds reset for two edges with both requesters valid, then checks the cleared state.
    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 2'b11;
        rsp_ready = 2'b00;
        @(negedge clk);
        check("ready_in_reset", {30'd0, req_ready}, 32'd0);
        step();
        step();
        rst       = 1'b0;
        req_valid = 2'b00;
        @(negedge clk);
        check("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("rst_rsp_sum", rsp_sum, 32'd0);
        check("rst_rsp_eq", {31'd0, rsp_eq}, 32'd0);
        check("rst_alu_op1", alu_op1, 32'd0);
        check("rst_alu_ctrl", {29'd0, alu_ctrl}, 32'd0);
        step();
    endtask

    // One full transaction with rsp_ready already high: accept, EXEC, RESP, back to IDLE.
    task automatic do_op(input string tag, input logic [1:0] exp_grant,
                         input logic [DW-1:0] exp_sum, input logic exp_eq);
        @(negedge clk);
        check({tag, "_ready"}, {30'd0, req_ready}, {30'd0, exp_grant});
        step();
        @(negedge clk);
        check({tag, "_exec_ready"}, {30'd0, req_ready}, 32'd0);
        check({tag, "_exec_valid"}, {30'd0, rsp_valid}, 32'd0);
        step();
        @(negedge clk);
        check({tag, "_rsp_valid"}, {30'd0, rsp_valid}, {30'd0, exp_grant});
        check({tag, "_rsp_sum"}, rsp_sum, exp_sum);
        check({tag, "_rsp_eq"}, {31'd0, rsp_eq}, {31'd0, exp_eq});
        step();
    endtask

    initial begin
        int j0;
        int j1;
        req_op1  = '0;
        req_op2  = '0;
        req_ctrl = '0;
        #1;
        do_reset();

        // Single requester 0: 5 + 7.
        set_req(0, 32'd5, 32'd7, 3'd0);
        rsp_ready = 2'b11;
        req_valid = 2'b01;
        @(negedge clk);
        check("t1_ready", {30'd0, req_ready}, 32'd1);
        step();
        req_valid = 2'b00;
        @(negedge clk);
        check("t1_alu_op1", alu_op1, 32'd5);
        check("t1_alu_op2", alu_op2, 32'd7);
        check("t1_exec_ready", {30'd0, req_ready}, 32'd0);
        step();
        @(negedge clk);
        check("t1_rsp_valid", {30'd0, rsp_valid}, 32'd1);
        check("t1_rsp_sum", rsp_sum, 32'd12);
        check("t1_rsp_eq", {31'd0, rsp_eq}, 32'd0);
        step();
        @(negedge clk);
        check("t1_idle_valid", {30'd0, rsp_valid}, 32'd0);
        check("t1_op1_retained", alu_op1, 32'd5);
        step();

        // Both requesters continuously valid: grants alternate 0,1,0,1...
        do_reset();
        j0 = 0;
        j1 = 0;
        set_req(0, 32'd16, 32'd0, 3'd0);
        set_req(1, 32'd100, 32'd0, 3'd1);
        rsp_ready = 2'b11;
        req_valid = 2'b11;
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) begin
                do_op("t2_r0", 2'b01, 32'(16 + 4 * j0), 1'b0);
                j0++;
                set_req(0, 32'(16 + j0), 32'(3 * j0), 3'd0);
            end else begin
                do_op("t2_r1", 2'b10, 32'(100 - 10 * j1), 1'b0);
                j1++;
                set_req(1, 32'd100, 32'(10 * j1), 3'd1);
            end
        end
        req_valid = 2'b00;
        step();

        // Requester 1 held in RESP for 5 cycles; rsp_ready[0] is ignored; requester 0 waits.
        do_reset();
        set_req(1, 32'h55, 32'h55, 3'd0);
        set_req(0, 32'd3, 32'd4, 3'd0);
        req_valid = 2'b10;
        @(negedge clk);
        check("t3_ready", {30'd0, req_ready}, 32'd2);
        step();
        req_valid = 2'b01;
        @(negedge clk);
        check("t3_exec_ready", {30'd0, req_ready}, 32'd0);
        step();
        rsp_ready = 2'b01;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t3_hold_valid", {30'd0, rsp_valid}, 32'd2);
            check("t3_hold_sum", rsp_sum, 32'hAA);
            check("t3_hold_eq", {31'd0, rsp_eq}, 32'd1);
            check("t3_hold_ready", {30'd0, req_ready}, 32'd0);
            step();
        end
        rsp_ready = 2'b10;
        @(negedge clk);
        check("t3_last_valid", {30'd0, rsp_valid}, 32'd2);
        step();
        rsp_ready = 2'b11;
        do_op("t3_r0", 2'b01, 32'd7, 1'b0);
        req_valid = 2'b00;
        step();

        // Reset during EXEC aborts the op.
        do_reset();
        set_req(0, 32'd9, 32'd9, 3'd0);
        rsp_ready = 2'b11;
        req_valid = 2'b01;
        @(negedge clk);
        check("t4_ready", {30'd0, req_ready}, 32'd1);
        step();
        req_valid = 2'b00;
        rst       = 1'b1;
        @(negedge clk);
        check("t4_ready_rst", {30'd0, req_ready}, 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("t4_valid", {30'd0, rsp_valid}, 32'd0);
        check("t4_sum", rsp_sum, 32'd0);
        check("t4_alu_op1", alu_op1, 32'd0);
        step();
        @(negedge clk);
        check("t4_no_rsp", {30'd0, rsp_valid}, 32'd0);
        req_valid = 2'b11;
        #1;
        check("t4_ptr0", {30'd0, req_ready}, 32'd1);
        req_valid = 2'b00;
        step();

        // Complete a requester 0 op (ptr moves to 1), then abort requester 1 in RESP.
        set_req(0, 32'd1, 32'd2, 3'd0);
        req_valid = 2'b01;
        do_op("t5_r0", 2'b01, 32'd3, 1'b0);
        set_req(1, 32'h20, 32'h22, 3'd0);
        rsp_ready = 2'b00;
        req_valid = 2'b10;
        step();
        req_valid = 2'b00;
        step();
        rst = 1'b1;
        @(negedge clk);
        check("t5_resp_valid", {30'd0, rsp_valid}, 32'd2);
        check("t5_resp_sum", rsp_sum, 32'h42);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("t5_valid", {30'd0, rsp_valid}, 32'd0);
        check("t5_sum", rsp_sum, 32'd0);
        req_valid = 2'b11;
        #1;
        check("t5_ptr0", {30'd0, req_ready}, 32'd1);
        req_valid = 2'b00;
        step();

        // Requester 1 alone, back-to-back, accepts every 3 cycles.
        do_reset();
        rsp_ready = 2'b11;
        set_req(1, 32'd7, 32'd7, 3'd0);
        req_valid = 2'b10;
        do_op("t6_a", 2'b10, 32'd14, 1'b1);
        set_req(1, 32'd50, 32'd8, 3'd1);
        do_op("t6_b", 2'b10, 32'd42, 1'b0);
        set_req(1, 32'd0, 32'd1, 3'd1);
        do_op("t6_c", 2'b10, 32'hFFFF_FFFF, 1'b0);
        req_valid = 2'b00;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
